// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle control unit: states, opcodes, funct codes,
// ALU codes, datapath select codes and the decoded instruction record.
package mc_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;
  localparam logic [5:0] FN_JR  = 6'b001000;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0100;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_OR  = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0010;
  localparam logic [3:0] ALU_LUI = 4'b0110;
  localparam logic [3:0] ALU_SLL = 4'b0011;
  localparam logic [3:0] ALU_SRL = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1111;

  localparam logic [1:0] ASEL_PC    = 2'd0;
  localparam logic [1:0] ASEL_RS    = 2'd1;
  localparam logic [1:0] ASEL_SHAMT = 2'd2;

  localparam logic [1:0] BSEL_RT     = 2'd0;
  localparam logic [1:0] BSEL_FOUR   = 2'd1;
  localparam logic [1:0] BSEL_IMM    = 2'd2;
  localparam logic [1:0] BSEL_BRANCH = 2'd3;

  localparam logic [1:0] PC_ALU    = 2'd0;
  localparam logic [1:0] PC_ALUOUT = 2'd1;
  localparam logic [1:0] PC_JUMP   = 2'd2;
  localparam logic [1:0] PC_RS     = 2'd3;

  typedef enum logic [3:0] {
    C_RTYPE,
    C_SHIFT,
    C_IMM_ARITH,
    C_IMM_LOGIC,
    C_LUI,
    C_LOAD,
    C_STORE,
    C_BRANCH,
    C_JUMP,
    C_ILLEGAL
  } iclass_t;

  typedef struct packed {
    iclass_t    cls;
    logic [3:0] aluc;
    logic       is_jal;
    logic       is_jr;
    logic       is_bne;
  } decode_t;

  // Instructions whose destination register comes from the rt field.
  function automatic logic writes_rt(input iclass_t cls);
    return (cls == C_IMM_ARITH) || (cls == C_IMM_LOGIC) ||
           (cls == C_LUI) || (cls == C_LOAD);
  endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder: instruction class, EXE ALU code and
// the few flags that distinguish members of the same class.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output decode_t    dec
);

  always_comb begin
    dec      = '0;
    dec.cls  = C_ILLEGAL;
    dec.aluc = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        case (func)
          FN_ADD:  begin dec.cls = C_RTYPE; dec.aluc = ALU_ADD; end
          FN_SUB:  begin dec.cls = C_RTYPE; dec.aluc = ALU_SUB; end
          FN_AND:  begin dec.cls = C_RTYPE; dec.aluc = ALU_AND; end
          FN_OR:   begin dec.cls = C_RTYPE; dec.aluc = ALU_OR;  end
          FN_XOR:  begin dec.cls = C_RTYPE; dec.aluc = ALU_XOR; end
          FN_SLL:  begin dec.cls = C_SHIFT; dec.aluc = ALU_SLL; end
          FN_SRL:  begin dec.cls = C_SHIFT; dec.aluc = ALU_SRL; end
          FN_SRA:  begin dec.cls = C_SHIFT; dec.aluc = ALU_SRA; end
          FN_JR:   begin dec.cls = C_JUMP;  dec.is_jr = 1'b1;   end
          default: dec.cls = C_ILLEGAL;
        endcase
      end
      OP_ADDI: dec.cls = C_IMM_ARITH;
      OP_ANDI: begin dec.cls = C_IMM_LOGIC; dec.aluc = ALU_AND; end
      OP_ORI:  begin dec.cls = C_IMM_LOGIC; dec.aluc = ALU_OR;  end
      OP_XORI: begin dec.cls = C_IMM_LOGIC; dec.aluc = ALU_XOR; end
      OP_LUI:  begin dec.cls = C_LUI;       dec.aluc = ALU_LUI; end
      OP_LW:   dec.cls = C_LOAD;
      OP_SW:   dec.cls = C_STORE;
      OP_BEQ:  begin dec.cls = C_BRANCH; dec.aluc = ALU_SUB; end
      OP_BNE:  begin dec.cls = C_BRANCH; dec.aluc = ALU_SUB; dec.is_bne = 1'b1; end
      OP_J:    dec.cls = C_JUMP;
      OP_JAL:  begin dec.cls = C_JUMP; dec.is_jal = 1'b1; end
      default: dec.cls = C_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle CPU control unit: sequences fetch/decode/execute/memory/write-back
// and drives datapath enables and selects; stalls on the shared memory ready.
//
//   state | meaning
//   IF    | fetch at PC, PC += 4; waits for mem_rdy
//   ID    | decode, ALUout <= branch target; jumps finish here
//   EXE   | ALU operation; branches resolve here
//   MEM   | load/store at ALUout; waits for mem_rdy
//   WB    | register file write
module mc_control
  import mc_pkg::*;
(
  input  logic       clk,
  input  logic       clrn,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_rdy,
  output logic       wpc,
  output logic       wir,
  output logic       wmem,
  output logic       wreg,
  output logic       iord,
  output logic       regrt,
  output logic       m2reg,
  output logic       jal,
  output logic       sext,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [3:0] aluc,
  output logic [1:0] pcsource,
  output logic [2:0] state,
  output logic       illegal
);

  state_t  state_q;
  state_t  state_d;
  decode_t dec;

  mc_decode u_decode (
    .op   (op),
    .func (func),
    .dec  (dec)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IF;
    else       state_q <= state_d;
  end

  assign state = state_q;

  always_comb begin
    state_d  = S_IF;
    wpc      = 1'b0;
    wir      = 1'b0;
    wmem     = 1'b0;
    wreg     = 1'b0;
    iord     = 1'b0;
    regrt    = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    sext     = 1'b0;
    alusrca  = ASEL_PC;
    alusrcb  = BSEL_RT;
    aluc     = ALU_ADD;
    pcsource = PC_ALU;
    illegal  = 1'b0;
    case (state_q)
      S_IF: begin
        alusrcb = BSEL_FOUR;
        wir     = mem_rdy;
        wpc     = mem_rdy;
        state_d = mem_rdy ? S_ID : S_IF;
      end
      S_ID: begin
        alusrcb = BSEL_BRANCH;
        sext    = 1'b1;
        if (dec.cls == C_JUMP) begin
          wpc      = 1'b1;
          pcsource = dec.is_jr ? PC_RS : PC_JUMP;
          wreg     = dec.is_jal;
          jal      = dec.is_jal;
          state_d  = S_IF;
        end else if (dec.cls == C_ILLEGAL) begin
          illegal = 1'b1;
          state_d = S_IF;
        end else begin
          state_d = S_EXE;
        end
      end
      S_EXE: begin
        case (dec.cls)
          C_RTYPE: begin
            alusrca = ASEL_RS;
            aluc    = dec.aluc;
            state_d = S_WB;
          end
          C_SHIFT: begin
            alusrca = ASEL_SHAMT;
            aluc    = dec.aluc;
            state_d = S_WB;
          end
          C_IMM_ARITH: begin
            alusrca = ASEL_RS;
            alusrcb = BSEL_IMM;
            sext    = 1'b1;
            state_d = S_WB;
          end
          C_IMM_LOGIC, C_LUI: begin
            alusrca = ASEL_RS;
            alusrcb = BSEL_IMM;
            aluc    = dec.aluc;
            state_d = S_WB;
          end
          C_LOAD, C_STORE: begin
            alusrca = ASEL_RS;
            alusrcb = BSEL_IMM;
            sext    = 1'b1;
            state_d = S_MEM;
          end
          C_BRANCH: begin
            alusrca  = ASEL_RS;
            aluc     = ALU_SUB;
            pcsource = PC_ALUOUT;
            wpc      = dec.is_bne ? ~z : z;
            state_d  = S_IF;
          end
          default: state_d = S_IF;
        endcase
      end
      S_MEM: begin
        // wmem is held through the stall; the memory commits on the mem_rdy cycle.
        iord = 1'b1;
        wmem = (dec.cls == C_STORE);
        if (mem_rdy) state_d = (dec.cls == C_LOAD) ? S_WB : S_IF;
        else         state_d = S_MEM;
      end
      S_WB: begin
        wreg    = 1'b1;
        regrt   = writes_rt(dec.cls);
        m2reg   = (dec.cls == C_LOAD);
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase
  end

endmodule

// File: tb/tb_mc_control.sv
// Directed bench for mc_control: walks instruction sequences cycle by cycle and
// compares the state and the full control word against hand-derived values.
module tb_mc_control;

  logic       clk;
  logic       clrn;
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_rdy;
  logic       wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext, illegal;
  logic [1:0] alusrca, alusrcb, pcsource;
  logic [3:0] aluc;
  logic [2:0] state;
  logic [19:0] cw;

  int checks = 0;
  int errors = 0;
  int commits = 0;

  mc_control dut (
    .clk      (clk),
    .clrn     (clrn),
    .op       (op),
    .func     (func),
    .z        (z),
    .mem_rdy  (mem_rdy),
    .wpc      (wpc),
    .wir      (wir),
    .wmem     (wmem),
    .wreg     (wreg),
    .iord     (iord),
    .regrt    (regrt),
    .m2reg    (m2reg),
    .jal      (jal),
    .sext     (sext),
    .alusrca  (alusrca),
    .alusrcb  (alusrcb),
    .aluc     (aluc),
    .pcsource (pcsource),
    .state    (state),
    .illegal  (illegal)
  );

  assign cw = {wpc, wir, wmem, wreg, iord, regrt, m2reg, jal, sext,
               alusrca, alusrcb, aluc, pcsource, illegal};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory-side view: a store commits on each rising edge where wmem and mem_rdy are both high.
  always @(posedge clk) begin
    if (clrn && wmem && mem_rdy) commits++;
  end

  function automatic logic [19:0] mk(input int wpc_e, wir_e, wmem_e, wreg_e, iord_e,
                                     regrt_e, m2reg_e, jal_e, sext_e, a_e, b_e,
                                     c_e, p_e, ill_e);
    return {wpc_e[0], wir_e[0], wmem_e[0], wreg_e[0], iord_e[0], regrt_e[0],
            m2reg_e[0], jal_e[0], sext_e[0], a_e[1:0], b_e[1:0], c_e[3:0],
            p_e[1:0], ill_e[0]};
  endfunction

  task automatic chk(input string tag, input logic [2:0] st_e, input logic [19:0] cw_e);
    checks++;
    assert (state === st_e) else begin
      errors++;
      $error("FAIL %s.state observed=%0d expected=%0d", tag, state, st_e);
    end
    checks++;
    assert (cw === cw_e) else begin
      errors++;
      $error("FAIL %s.ctrl observed=%05h expected=%05h", tag, cw, cw_e);
    end
  endtask

  task automatic cyc(input string tag, input logic [2:0] st_e, input logic [19:0] cw_e);
    #1;
    chk(tag, st_e, cw_e);
    @(posedge clk);
    #2;
  endtask

  task automatic chk_commits(input string tag, input int exp);
    checks++;
    assert (commits === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, commits, exp);
    end
  endtask

  logic [19:0] if1, if0, idw;

  initial begin
    //          wpc wir wm wr io rt m2 jl sx  a  b  aluc    p  il
    if1 = mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'b0000, 0, 0);
    if0 = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 'b0000, 0, 0);
    idw = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 'b0000, 0, 0);

    clrn = 1'b0; op = 6'b000000; func = 6'b100000; z = 1'b0; mem_rdy = 1'b0;
    #3;
    chk("rst_rdy0", 3'd0, if0);
    mem_rdy = 1'b1;
    #1;
    chk("rst_rdy1", 3'd0, if1);
    @(posedge clk); #2;
    clrn = 1'b1;

    // add
    op = 6'b000000; func = 6'b100000;
    cyc("add_if",  3'd0, if1);
    cyc("add_id",  3'd1, idw);
    cyc("add_exe", 3'd2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'b0000, 0, 0));
    cyc("add_wb",  3'd4, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));

    // lw with a 3-cycle memory stall
    op = 6'b100011; func = 6'b000000;
    cyc("lw_if",  3'd0, if1);
    cyc("lw_id",  3'd1, idw);
    cyc("lw_exe", 3'd2, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 'b0000, 0, 0));
    mem_rdy = 1'b0;
    cyc("lw_mem_stall1", 3'd3, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));
    cyc("lw_mem_stall2", 3'd3, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));
    cyc("lw_mem_stall3", 3'd3, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));
    mem_rdy = 1'b1;
    cyc("lw_mem_done",   3'd3, mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));
    cyc("lw_wb",         3'd4, mk(0, 0, 0, 1, 0, 1, 1, 0, 0, 0, 0, 'b0000, 0, 0));

    // fetch stall: IF holds with no enables while mem_rdy is low
    op = 6'b000100; z = 1'b1; mem_rdy = 1'b0;
    cyc("if_stall", 3'd0, if0);
    mem_rdy = 1'b1;
    cyc("beq1_if",  3'd0, if1);
    cyc("beq1_id",  3'd1, idw);
    cyc("beq1_exe", 3'd2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'b0100, 1, 0));

    z = 1'b0;
    cyc("beq0_if",  3'd0, if1);
    cyc("beq0_id",  3'd1, idw);
    cyc("beq0_exe", 3'd2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'b0100, 1, 0));

    op = 6'b000101;
    cyc("bne0_if",  3'd0, if1);
    cyc("bne0_id",  3'd1, idw);
    cyc("bne0_exe", 3'd2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'b0100, 1, 0));
    z = 1'b1;
    cyc("bne1_if",  3'd0, if1);
    cyc("bne1_id",  3'd1, idw);
    cyc("bne1_exe", 3'd2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 'b0100, 1, 0));
    z = 1'b0;

    // jumps
    op = 6'b000011;
    cyc("jal_if", 3'd0, if1);
    cyc("jal_id", 3'd1, mk(1, 0, 0, 1, 0, 0, 0, 1, 1, 0, 3, 'b0000, 2, 0));
    op = 6'b000010;
    cyc("j_if",   3'd0, if1);
    cyc("j_id",   3'd1, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 'b0000, 2, 0));
    op = 6'b000000; func = 6'b001000;
    cyc("jr_if",  3'd0, if1);
    cyc("jr_id",  3'd1, mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 'b0000, 3, 0));

    // sra
    func = 6'b000011;
    cyc("sra_if",  3'd0, if1);
    cyc("sra_id",  3'd1, idw);
    cyc("sra_exe", 3'd2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 'b1111, 0, 0));
    cyc("sra_wb",  3'd4, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));

    // ori: zero-extended immediate, rt destination
    op = 6'b001101;
    cyc("ori_if",  3'd0, if1);
    cyc("ori_id",  3'd1, idw);
    cyc("ori_exe", 3'd2, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 'b0101, 0, 0));
    cyc("ori_wb",  3'd4, mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 'b0000, 0, 0));

    // addi: sign-extended
    op = 6'b001000;
    cyc("addi_if",  3'd0, if1);
    cyc("addi_id",  3'd1, idw);
    cyc("addi_exe", 3'd2, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 'b0000, 0, 0));
    cyc("addi_wb",  3'd4, mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 'b0000, 0, 0));

    // unsupported opcode and unsupported R-type funct
    op = 6'b111111;
    cyc("ill_op_if", 3'd0, if1);
    cyc("ill_op_id", 3'd1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 'b0000, 0, 1));
    op = 6'b000000; func = 6'b111111;
    cyc("ill_fn_if", 3'd0, if1);
    cyc("ill_fn_id", 3'd1, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 3, 'b0000, 0, 1));

    // sw with a 2-cycle stall commits exactly once
    op = 6'b101011; func = 6'b000000;
    cyc("sw_if",  3'd0, if1);
    cyc("sw_id",  3'd1, idw);
    cyc("sw_exe", 3'd2, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 'b0000, 0, 0));
    mem_rdy = 1'b0;
    cyc("sw_mem_stall1", 3'd3, mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));
    cyc("sw_mem_stall2", 3'd3, mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));
    chk_commits("sw_commits_stall", 0);
    mem_rdy = 1'b1;
    cyc("sw_mem_done",   3'd3, mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));
    chk_commits("sw_commits_once", 1);

    // sw aborted by reset during its MEM stall
    cyc("swr_if",  3'd0, if1);
    cyc("swr_id",  3'd1, idw);
    cyc("swr_exe", 3'd2, mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 2, 'b0000, 0, 0));
    mem_rdy = 1'b0;
    cyc("swr_mem", 3'd3, mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));
    #1;
    chk("swr_mem_held", 3'd3, mk(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 'b0000, 0, 0));
    clrn = 1'b0;
    #1;
    chk("swr_reset", 3'd0, if0);
    @(posedge clk); #2;
    clrn = 1'b1;
    cyc("swr_after", 3'd0, if0);
    chk_commits("swr_no_commit", 1);
    mem_rdy = 1'b1;
    cyc("swr_refetch", 3'd0, if1);
    chk("swr_refetch_id", 3'd1, idw);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
